matmul_loader: RTL and testbench
================================

Name: matmul_loader

Overview:
Upstream feeder for matmul_top. It accepts a byte stream over a valid/ready handshake and packs it into 32-bit words. It writes matrix A to A_BASE..A_BASE+3 and matrix B to B_BASE..B_BASE+3 through a memory write port. It then pulses kick_start to matmul_top, tracks matmul ready until the job completes, and reports completion upstream.

Parameters:
- ADDR_W, 10, memory word address width
- DATA_W, 32, memory word width (4 bytes per word)
- DIM, 4, matrix dimension; words per matrix = DIM, bytes per word = DIM
- A_BASE, 10'h000, first word address of matrix A
- B_BASE, 10'h100, first word address of matrix B
- TIMEOUT_CYCLES, 4096, watchdog limit (optional feature only)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a load-and-run job
- busy  out  1  high from accepted start until done/err
- done  out  1  one-cycle pulse when matmul job completes
- err  out  1  one-cycle pulse on watchdog expiry (tied 0 without macro)
- s_valid  in  1  stream byte valid
- s_ready  out  1  stream byte accept
- s_data  in  8  stream byte
- mem_write_en  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory write address
- mem_data  out  DATA_W  memory write data
- mm_ready  in  1  matmul_top ready
- kick_start  out  1  one-cycle start to matmul_top

Behaviour:
- Reset values: busy=0, done=0, err=0, s_ready=0, mem_write_en=0, mem_addr=0, mem_data=0, kick_start=0. State=IDLE, counters and packing register are cleared.
- States: IDLE -> LOAD_A -> LOAD_B -> KICK -> WAIT_BUSY -> WAIT_DONE -> IDLE.
- IDLE: start=1 moves to LOAD_A, clears byte_cnt and word_cnt, and sets busy. start is ignored in every other state.
- LOAD_A / LOAD_B:
  - s_ready=1 continuously. A byte transfers on s_valid&&s_ready.
  - Byte k of a word (k=0..3) goes to pack[8k+7:8k], so the first byte lands in the LSB.
  - On the 4th byte, the next cycle registers mem_write_en=1 for exactly one cycle, with mem_data set to the packed word and mem_addr = base+word_cnt.
  - Throughput is 1 byte/cycle with no stalls.
  - After word DIM-1 of A, go to LOAD_B. After word DIM-1 of B, go to KICK. s_ready drops in the cycle the state leaves LOAD_B.
- Write latency: 1 cycle after the last byte of a word.
- KICK: waits for the final B write to retire. It then waits for mm_ready=1, drives kick_start=1 for exactly one cycle, and goes to WAIT_BUSY.
- WAIT_BUSY: waits for mm_ready=0, then goes to WAIT_DONE.
- WAIT_DONE: on mm_ready=1, pulse done for one cycle, clear busy, and return to IDLE.
- s_valid while s_ready=0 is ignored; no byte is consumed.
- A partial word is never written.
- Reset mid-operation: returns to IDLE immediately. Partial words are discarded; memory writes already issued stand.
- Transfers are unbounded; only the first 2*DIM*DIM bytes of a job are accepted.

Optional Feature:
- Macro: MATMUL_LOADER_TIMEOUT_EN.
- Defined: a cycle counter runs in KICK, WAIT_BUSY and WAIT_DONE. On reaching TIMEOUT_CYCLES, pulse err for one cycle, clear busy, force kick_start=0, and return to IDLE; done is not pulsed.
- Undefined: no counter; err is constant 0, and the block waits indefinitely.

Decomposition:
- Shared package matmul_pkg holds:
  - ADDR_W and DATA_W
  - base addresses A_BASE=10'h000, B_BASE=10'h100, C_BASE=10'h200
  - DIM
  - the loader state enum encoding
- One sub-module, byte_packer: 8-bit-in to 32-bit-out shift/pack register with byte counter and word_valid pulse. The FSM, addressing and handshake stay in matmul_loader.

Test Plan:
- Basic load: start, then stream bytes 1..16 (A) and 3,4,1,2,7,8,5,6,11,12,9,10,15,16,13,14 (B) with s_valid held high.
  - mem[0x000]=32'h04030201, mem[0x003]=32'h100F0E0D
  - mem[0x100]=32'h02010403, mem[0x103]=32'h0E0D100F
  - 8 writes total, each 1 cycle after the 4th byte of its word
- Kick handshake: mm_ready held 0 at end of load, raised 5 cycles later -> kick_start high exactly 1 cycle, after mm_ready=1. Bench model drops mm_ready for 20 cycles -> done pulses 1 cycle after mm_ready returns, and busy falls the same cycle.
- Backpressure/gaps: s_valid toggles randomly (50%) -> same memory contents as the basic-load test. No write is issued for a partial word, and s_data is ignored while s_valid=0.
- Ignored inputs:
  - start asserted during LOAD_B -> no restart, counters unaffected
  - s_valid=1 in IDLE -> s_ready=0, nothing written
- Reset mid-load: rstn low after 6 A bytes -> all outputs at reset values. mem[0x000] still holds the word already written; no write occurs to 0x001. A new job then completes normally.
- Timeout (MATMUL_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=64): mm_ready never returns after kick -> err pulses 1 cycle, 64 cycles after entering KICK. done stays 0, busy falls, and state returns to IDLE.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared widths, base addresses and loader state encoding
// for the matmul feeder slice.
package matmul_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DIM    = 4;
    localparam int CNT_W  = $clog2(DIM);

    localparam logic [ADDR_W-1:0] A_BASE = 10'h000;
    localparam logic [ADDR_W-1:0] B_BASE = 10'h100;
    localparam logic [ADDR_W-1:0] C_BASE = 10'h200;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_KICK,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } ld_state_e;

endpackage

// File: rtl/matmul_loader_byte_packer.sv
// Packs an 8-bit stream into DATA_W words, first byte in the LSB.
// word_valid_o fires combinationally with the byte that completes a word.
module byte_packer
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr_i,
    input  logic              valid_i,
    input  logic [7:0]        data_i,
    output logic              word_valid_o,
    output logic [DATA_W-1:0] word_o
);

    // only the first DIM-1 bytes are held; the last one is merged on the fly
    logic [DATA_W-9:0] pack_q;
    logic [CNT_W-1:0]  cnt_q;

    assign word_valid_o = valid_i && (cnt_q == CNT_W'(DIM - 1));
    assign word_o       = {data_i, pack_q};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pack_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            pack_q <= '0;
            cnt_q  <= '0;
        end else if (valid_i) begin
            for (int k = 0; k < DIM - 1; k++) begin
                if (cnt_q == CNT_W'(k)) pack_q[8*k +: 8] <= data_i;
            end
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/matmul_loader.sv
// Streams A and B into memory, kicks matmul_top and waits for completion.
// Optional watchdog: define MATMUL_LOADER_TIMEOUT_EN.
module matmul_loader
  import matmul_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
)
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mm_ready,
  output logic              kick_start
);

  ld_state_e         state_q;
  logic [CNT_W-1:0]  word_cnt_q;
  logic              busy_q, done_q, s_ready_q, we_q, kick_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              acc, word_vld;
  logic [DATA_W-1:0] word;

  assign acc = s_valid && s_ready_q;

  byte_packer u_packer (
    .clk          (clk),
    .rstn         (rstn),
    .clr_i        (state_q == S_IDLE),
    .valid_i      (acc),
    .data_i       (s_data),
    .word_valid_o (word_vld),
    .word_o       (word)
  );

`ifdef MATMUL_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tmo_q;
  logic          err_q, run, expire;

  assign run    = state_q inside {S_KICK, S_WAIT_BUSY, S_WAIT_DONE};
  assign expire = run && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign err    = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    tmo_q <= '0;
    else if (run) tmo_q <= tmo_q + 1'b1;
    else          tmo_q <= '0;
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      s_ready_q  <= 1'b0;
      we_q       <= 1'b0;
      kick_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
`ifdef MATMUL_LOADER_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      kick_q <= 1'b0;
`ifdef MATMUL_LOADER_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_LOAD_A;
            busy_q     <= 1'b1;
            s_ready_q  <= 1'b1;
            word_cnt_q <= '0;
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (word_vld) begin
            we_q       <= 1'b1;
            data_q     <= word;
            addr_q     <= ((state_q == S_LOAD_A) ? A_BASE : B_BASE)
                          + ADDR_W'(word_cnt_q);
            word_cnt_q <= word_cnt_q + 1'b1;
            if (word_cnt_q == CNT_W'(DIM - 1)) begin
              word_cnt_q <= '0;
              if (state_q == S_LOAD_A) begin
                state_q <= S_LOAD_B;
              end else begin
                state_q   <= S_KICK;
                s_ready_q <= 1'b0;
              end
            end
          end
        end
        S_KICK: begin
          if (!we_q && mm_ready) begin
            kick_q  <= 1'b1;
            state_q <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (!mm_ready) state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (mm_ready) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
`ifdef MATMUL_LOADER_TIMEOUT_EN
      if (expire) begin
        err_q   <= 1'b1;
        done_q  <= 1'b0;
        busy_q  <= 1'b0;
        kick_q  <= 1'b0;
        state_q <= S_IDLE;
      end
`endif
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign s_ready      = s_ready_q;
  assign mem_write_en = we_q;
  assign mem_addr     = addr_q;
  assign mem_data     = data_q;
  assign kick_start   = kick_q;

endmodule

// File: tb/tb_matmul_loader.sv
// Scoreboard bench for matmul_loader: random byte streams, a packing
// model, and a handshake model of matmul_top.
module tb_matmul_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        mm_ready = 1'b1;
  logic        busy, done, err, s_ready, mem_write_en, kick_start;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
    int          c;
  } wr_t;

  wr_t  wq[$];
  int   kq[$];
  int   dq[$];
  int   eq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] mem [1024];
  logic [7:0]  tpb [16] = '{3, 4, 1, 2, 7, 8, 5, 6, 11, 12, 9, 10, 15, 16, 13, 14};

  matmul_loader #(.TIMEOUT_CYCLES(64)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mm_ready     (mm_ready),
    .kick_start   (kick_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected pulse at cycle %0d", nm, cyc);
  endtask

  always @(negedge clk) begin
    wr_t e;
    int  c;
    if (mem_write_en) begin
      if (wq.size() == 0) unexpected("write");
      else begin
        e = wq.pop_front();
        chk("wr_addr", mem_addr, e.a);
        chk("wr_data", mem_data, e.d);
        chk("wr_cycle", cyc, e.c);
      end
      mem[mem_addr] = mem_data;
    end
    if (kick_start) begin
      if (kq.size() == 0) unexpected("kick");
      else begin c = kq.pop_front(); chk("kick_cycle", cyc, c); end
    end
    if (done) begin
      if (dq.size() == 0) unexpected("done");
      else begin c = dq.pop_front(); chk("done_cycle", cyc, c); end
      chk("busy_at_done", busy, 0);
    end
    if (err) begin
      if (eq.size() == 0) unexpected("err");
      else begin c = eq.pop_front(); chk("err_cycle", cyc, c); end
      chk("busy_at_err", busy, 0);
    end
  end

  task automatic run_job(input bit tp, input bit gaps, input bit start_in_b, input bit tmo);
    logic [7:0] b [32];
    int  k;
    int  last;
    wr_t e;
    for (int i = 0; i < 32; i++) begin
      if (tp) b[i] = (i < 16) ? 8'(i + 1) : tpb[i-16];
      else    b[i] = 8'($urandom);
    end
    mm_ready = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    last = 0;
    while (k < 32) begin
      chk("s_ready_load", s_ready, 1);
      chk("busy_load", busy, 1);
      if (gaps && $urandom_range(1) == 0) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
      end else begin
        s_valid = 1'b1;
        s_data  = b[k];
        if (k % 4 == 3) begin
          e.a = (k < 16) ? 10'h000 + 10'(k / 4) : 10'h100 + 10'((k - 16) / 4);
          e.d = {b[k], b[k-1], b[k-2], b[k-3]};
          e.c = cyc + 1;
          wq.push_back(e);
        end
        last = cyc;
        k++;
      end
      start = (start_in_b && k == 20) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b0;
    start   = 1'b0;
    chk("s_ready_after_load", s_ready, 0);
    repeat (4) @(negedge clk);
    mm_ready = 1'b1;
    kq.push_back(cyc + 1);
    @(negedge clk);
    mm_ready = 1'b0;
    if (tmo) begin
      eq.push_back(last + 65);
      repeat (70) @(negedge clk);
      chk("busy_after_err", busy, 0);
      mm_ready = 1'b1;
    end else begin
      repeat (19) @(negedge clk);
      chk("busy_wait_done", busy, 1);
      mm_ready = 1'b1;
      dq.push_back(cyc + 1);
      @(negedge clk);
      @(negedge clk);
      chk("busy_after_done", busy, 0);
    end
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_s_ready"}, s_ready, 0);
    chk({nm, "_we"}, mem_write_en, 0);
    chk({nm, "_addr"}, mem_addr, 0);
    chk({nm, "_data"}, mem_data, 0);
    chk({nm, "_kick"}, kick_start, 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  endtask

  task automatic chk_tp_mem();
    chk("mem_000", mem[10'h000], 32'h04030201);
    chk("mem_003", mem[10'h003], 32'h100F0E0D);
    chk("mem_100", mem[10'h100], 32'h02010403);
    chk("mem_103", mem[10'h103], 32'h0E0D100F);
  endtask

  initial begin
    logic [7:0] rb [6];
    wr_t e;
    clear_mem();
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rstn = 1'b1;
    @(negedge clk);

    s_valid = 1'b1;
    repeat (3) begin
      s_data = 8'($urandom);
      @(negedge clk);
      chk("s_ready_idle", s_ready, 0);
    end
    s_valid = 1'b0;

    run_job(1'b1, 1'b0, 1'b0, 1'b0);
    chk_tp_mem();
    clear_mem();
    run_job(1'b1, 1'b1, 1'b1, 1'b0);
    chk_tp_mem();
    for (int j = 0; j < 3; j++) run_job(1'b0, j[0], 1'b0, 1'b0);

    mem[10'h000] = 32'h0;
    mem[10'h001] = 32'hDEADBEEF;
    for (int i = 0; i < 6; i++) rb[i] = 8'($urandom);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1;
      s_data  = rb[i];
      if (i == 3) begin
        e.a = 10'h000;
        e.d = {rb[3], rb[2], rb[1], rb[0]};
        e.c = cyc + 1;
        wq.push_back(e);
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk_reset_outs("midload_reset");
    chk("mem_000_kept", mem[10'h000], {rb[3], rb[2], rb[1], rb[0]});
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("mem_001_untouched", mem[10'h001], 32'hDEADBEEF);
    run_job(1'b0, 1'b1, 1'b0, 1'b0);

`ifdef MATMUL_LOADER_TIMEOUT_EN
    run_job(1'b0, 1'b0, 1'b0, 1'b1);
    run_job(1'b0, 1'b1, 1'b0, 1'b0);
`endif

    repeat (5) @(negedge clk);
    chk("writes_pending", wq.size(), 0);
    chk("kicks_pending", kq.size(), 0);
    chk("dones_pending", dq.size(), 0);
    chk("errs_pending", eq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
